// File: rtl/synapse_pkg.sv
// -----------------------------------------------------------------------------
// synapse_pkg
// Shared types and constants for the synapse scheduler block.
//   cur_t        : 18-bit two's complement synapse current / weight type
//   CUR_MAX/MIN  : clamp bounds used when SYN_SATURATE_EN is defined
//   state_t      : scheduler FSM state encoding
// -----------------------------------------------------------------------------
package synapse_pkg;

    localparam int CUR_W = 18;

    typedef logic signed [CUR_W-1:0] cur_t;

    localparam cur_t CUR_MAX = 18'sh1FFFF;   //  131071
    localparam cur_t CUR_MIN = 18'sh20000;   // -131072

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DECAY = 3'd1,
        ST_ACCUM = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/synapse_sat_add.sv
// -----------------------------------------------------------------------------
// synapse_sat_add
// Single 18-bit two's complement adder/subtractor shared by the decay and
// accumulate steps of the scheduler.
//   a, b : signed 18-bit operands
//   sub  : 1 -> y = a - b, 0 -> y = a + b
//   y    : signed 18-bit result
// Build option: SYN_SATURATE_EN defined -> result clamps to [CUR_MIN, CUR_MAX];
// undefined (default) -> result wraps modulo 2^18.
// -----------------------------------------------------------------------------
module synapse_sat_add
    import synapse_pkg::*;
(
    input  logic signed [17:0] a,
    input  logic signed [17:0] b,
    input  logic               sub,
    output logic signed [17:0] y
);

`ifdef SYN_SATURATE_EN
    // One guard bit: overflow shows up as the top two bits disagreeing.
    logic signed [18:0] wide;

    assign wide = sub ? ({a[17], a} - {b[17], b}) : ({a[17], a} + {b[17], b});

    always_comb begin
        if (wide[18] != wide[17]) begin
            y = wide[18] ? CUR_MIN : CUR_MAX;
        end else begin
            y = wide[17:0];
        end
    end
`else
    assign y = sub ? (a - b) : (a + b);
`endif

endmodule

// File: rtl/synapse_scheduler.sv
// -----------------------------------------------------------------------------
// synapse_scheduler
// Per-timestep synapse current update. On an accepted tick every synapse i is
// decayed (v - v>>>DECAY_SHIFT), the weight of each active presynaptic input is
// fetched from an external memory and accumulated, and the result is written
// back and reported on cur_valid/cur_idx/cur_val.
//
// Ports
//   clock      : sole clock, rising edge
//   reset      : synchronous, active-high
//   tick       : start one timestep (accepted only in IDLE)
//   spikes     : presynaptic spike vector, sampled on the accepted tick
//   wt_rd      : weight read strobe (combinational, ACCUM cycles only)
//   wt_addr    : weight address i*NUM_PRE + j, holds last value when idle
//   wt_data    : weight, valid exactly one cycle after wt_rd
//   busy       : high from the cycle after an accepted tick until done
//   done       : one-cycle pulse at end of timestep
//   cur_valid  : one-cycle pulse per synapse write-back
//   cur_idx    : index of written synapse
//   cur_val    : new current of written synapse
//   overrun    : sticky, set by a tick arriving while not IDLE
//   fsm_state  : current FSM state (debug visibility, encoding of state_t)
//
// Handshake: wt_rd is a one-cycle request with no back-pressure; the memory
// must present wt_data on the cycle immediately following the strobe.
//
// Build option: SYN_SATURATE_EN (see synapse_sat_add) selects saturating
// arithmetic; default is wrapping.
// -----------------------------------------------------------------------------
module synapse_scheduler
    import synapse_pkg::*;
#(
    parameter int NUM_SYN     = 8,
    parameter int NUM_PRE     = 3,
    parameter int DECAY_SHIFT = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               tick,
    input  logic [NUM_PRE-1:0]                 spikes,
    output logic                               wt_rd,
    output logic [$clog2(NUM_SYN*NUM_PRE)-1:0] wt_addr,
    input  logic signed [17:0]                 wt_data,
    output logic                               busy,
    output logic                               done,
    output logic                               cur_valid,
    output logic [$clog2(NUM_SYN)-1:0]         cur_idx,
    output logic signed [17:0]                 cur_val,
    output logic                               overrun,
    output logic [2:0]                         fsm_state
);

    localparam int ADDR_W = $clog2(NUM_SYN*NUM_PRE);
    localparam int IDX_W  = $clog2(NUM_SYN);
    localparam int J_W    = $clog2(NUM_PRE+1);

    state_t             state;
    cur_t               v [NUM_SYN];
    cur_t               acc;
    logic [IDX_W-1:0]   i;
    logic [J_W-1:0]     j;
    logic [NUM_PRE-1:0] spikes_q;
    logic [ADDR_W-1:0]  addr_q;

    // Shared adder operands: DECAY computes v[i] - (v[i] >>> DECAY_SHIFT),
    // WAIT computes acc + wt_data.
    cur_t               add_a;
    cur_t               add_b;
    logic               add_sub;
    cur_t               add_y;
    cur_t               v_i;

    logic [NUM_PRE-1:0] spk_sh;
    logic               spk_j;
    logic               j_end;
    logic [ADDR_W-1:0]  rd_addr;

    assign v_i     = v[i];
    // Shift rather than index so j == NUM_PRE never addresses past the vector.
    assign spk_sh  = spikes_q >> j;
    assign spk_j   = spk_sh[0];
    assign j_end   = (j == J_W'(NUM_PRE));
    assign rd_addr = ADDR_W'(i) * ADDR_W'(NUM_PRE) + ADDR_W'(j);

    always_comb begin
        add_a   = acc;
        add_b   = wt_data;
        add_sub = 1'b0;
        if (state == ST_DECAY) begin
            add_a   = v_i;
            add_b   = v_i >>> DECAY_SHIFT;
            add_sub = 1'b1;
        end
    end

    synapse_sat_add u_add (
        .a   (add_a),
        .b   (add_b),
        .sub (add_sub),
        .y   (add_y)
    );

    // The strobe must coincide with the ACCUM cycle so data lands in WAIT;
    // the address register only remembers the last issued address.
    assign wt_rd     = (state == ST_ACCUM) && !j_end && spk_j;
    assign wt_addr   = wt_rd ? rd_addr : addr_q;
    assign fsm_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            acc       <= '0;
            i         <= '0;
            j         <= '0;
            spikes_q  <= '0;
            addr_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cur_valid <= 1'b0;
            cur_idx   <= '0;
            cur_val   <= '0;
            overrun   <= 1'b0;
            for (int k = 0; k < NUM_SYN; k++) begin
                v[k] <= '0;
            end
        end else begin
            done      <= 1'b0;
            cur_valid <= 1'b0;

            if (tick && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            if (wt_rd) begin
                addr_q <= rd_addr;
            end

            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        spikes_q <= spikes;
                        i        <= '0;
                        busy     <= 1'b1;
                        state    <= ST_DECAY;
                    end
                end
                ST_DECAY: begin
                    acc   <= add_y;
                    j     <= '0;
                    state <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (j_end) begin
                        state <= ST_WRITE;
                    end else if (spk_j) begin
                        state <= ST_WAIT;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                ST_WAIT: begin
                    acc   <= add_y;
                    j     <= j + 1'b1;
                    state <= ST_ACCUM;
                end
                ST_WRITE: begin
                    v[i]      <= acc;
                    cur_idx   <= i;
                    cur_val   <= acc;
                    cur_valid <= 1'b1;
                    if (i == IDX_W'(NUM_SYN-1)) begin
                        state <= ST_DONE;
                    end else begin
                        i     <= i + 1'b1;
                        state <= ST_DECAY;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
